// File: rtl/led_scan_driver_if.sv
// rtl/led_scan_driver_if.sv - LED data inputs and matrix/aux drive outputs of the scan driver
interface led_scan_driver_if #(
  parameter int BRIGHT_W = 5
);
  logic                en;
  logic [BRIGHT_W-1:0] bright;
  logic [3:0]          LED0;
  logic [3:0]          LED1;
  logic [3:0]          LED2;
  logic [3:0]          LED3;
  logic                LED4;
  logic                LED5;
  logic [3:0]          ROW;
  logic [3:0]          COL;
  logic [1:0]          AUX;
  logic                frame_done;

  modport master (
    output en, bright, LED0, LED1, LED2, LED3, LED4, LED5,
    input  ROW, COL, AUX, frame_done
  );

  modport slave (
    input  en, bright, LED0, LED1, LED2, LED3, LED4, LED5,
    output ROW, COL, AUX, frame_done
  );
endinterface

// File: rtl/led_scan_driver.sv
// rtl/led_scan_driver.sv - 4x4 row-scanned LED matrix driver with blanking, per-frame snapshot and PWM
module led_scan_driver #(
  parameter int DWELL    = 16,
  parameter int BRIGHT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  led_scan_driver_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [BRIGHT_W-1:0] CNT_LAST = BRIGHT_W'(DWELL - 1);

  state_t              state_q, state_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [BRIGHT_W-1:0] cnt_q, cnt_d;
  logic [3:0][3:0]     snap_q, snap_d;
  logic [1:0]          snap_aux_q, snap_aux_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [3:0]          row_out_q, row_out_d;
  logic [3:0]          col_q, col_d;
  logic [1:0]          aux_q, aux_d;
  logic                frame_done_q, frame_done_d;
  logic                drive;
  logic                on;

  // Outputs are computed from the next state so each registered value lines up
  // with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    row_idx_d    = row_idx_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    snap_aux_d   = snap_aux_q;
    bright_d     = bright_q;
    row_out_d    = 4'b0000;
    col_d        = 4'b0000;
    aux_d        = 2'b00;
    frame_done_d = 1'b0;
    drive        = 1'b0;
    on           = 1'b0;

    if (!bus.en) begin
      state_d   = IDLE;
      row_idx_d = 2'd0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          row_idx_d = 2'd0;
          cnt_d     = '0;
        end
        BLANK: begin
          state_d = DRIVE;
          cnt_d   = '0;
          drive   = 1'b1;
          if (row_idx_q == 2'd0) begin
            snap_d     = {bus.LED3, bus.LED2, bus.LED1, bus.LED0};
            snap_aux_d = {bus.LED5, bus.LED4};
            bright_d   = bus.bright;
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d      = BLANK;
            row_idx_d    = row_idx_q + 2'd1;
            cnt_d        = '0;
            frame_done_d = (row_idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
            drive = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          row_idx_d = 2'd0;
          cnt_d     = '0;
        end
      endcase
    end

    if (drive) begin
      on        = (cnt_d < bright_d);
      row_out_d = 4'b0001 << row_idx_d;
      col_d     = on ? snap_d[row_idx_d] : 4'b0000;
      aux_d     = on ? snap_aux_d : 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_idx_q    <= 2'd0;
      cnt_q        <= '0;
      snap_q       <= '0;
      snap_aux_q   <= 2'b00;
      bright_q     <= '0;
      row_out_q    <= 4'b0000;
      col_q        <= 4'b0000;
      aux_q        <= 2'b00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      snap_aux_q   <= snap_aux_d;
      bright_q     <= bright_d;
      row_out_q    <= row_out_d;
      col_q        <= col_d;
      aux_q        <= aux_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ROW        = row_out_q;
  assign bus.COL        = col_q;
  assign bus.AUX        = aux_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// tb/tb_led_scan_driver.sv - directed scoreboard bench for led_scan_driver (DWELL=4, BRIGHT_W=3)
module tb_led_scan_driver;

  localparam int DWELL    = 4;
  localparam int BRIGHT_W = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Expected {ROW, COL, AUX, frame_done} per clock cycle.
  logic [10:0] exp_q[$];

  led_scan_driver_if #(.BRIGHT_W(BRIGHT_W)) bus ();

  led_scan_driver #(.DWELL(DWELL), .BRIGHT_W(BRIGHT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] observed();
    return {bus.ROW, bus.COL, bus.AUX, bus.frame_done};
  endfunction

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(11'd0);
  endtask

  task automatic push_frame(input logic [3:0] l0, input logic [3:0] l1,
                            input logic [3:0] l2, input logic [3:0] l3,
                            input logic [1:0] aux, input int br, input bit fd);
    logic [3:0] rows [4];
    logic [3:0] sel;
    bit         lit;
    rows[0] = l0; rows[1] = l1; rows[2] = l2; rows[3] = l3;
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back({4'b0000, 4'b0000, 2'b00, (fd && r == 0)});
      for (int c = 0; c < DWELL; c++) begin
        sel = 4'b0001 << r;
        lit = (c < br);
        exp_q.push_back({sel, lit ? rows[r] : 4'b0000, lit ? aux : 2'b00, 1'b0});
      end
    end
  endtask

  task automatic check_now(input string tag);
    logic [10:0] exp_v;
    logic [10:0] obs_v;
    bit          have;
    checks++;
    have = (exp_q.size() > 0);
    assert (have) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, observed());
    end
    if (have) begin
      exp_v = exp_q.pop_front();
      obs_v = observed();
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s observed ROW/COL/AUX/fd=%b_%b_%b_%b expected=%b_%b_%b_%b",
               tag, obs_v[10:7], obs_v[6:3], obs_v[2:1], obs_v[0],
               exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_now(tag);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    run(n, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.bright = '0;
    bus.LED0 = 4'h0; bus.LED1 = 4'h0; bus.LED2 = 4'h0; bus.LED3 = 4'h0;
    bus.LED4 = 1'b0; bus.LED5 = 1'b0;

    #12;
    exp_q.push_back(11'd0);
    check_now("reset_state");
    @(negedge clk);
    rst = 1'b0;
    push_zeros(2);
    run(2, "idle");

    // Basic scan, then LED1 changed during row 0 drive: visible only next frame.
    bus.bright = 3'd4;
    bus.LED0 = 4'hA; bus.LED1 = 4'h5; bus.LED2 = 4'hC; bus.LED3 = 4'h3;
    bus.en = 1'b1;
    push_frame(4'hA, 4'h5, 4'hC, 4'h3, 2'b00, 4, 1'b0);
    push_frame(4'hA, 4'h3, 4'hC, 4'h3, 2'b00, 4, 1'b1);
    run(3, "frame1_row0");
    bus.LED1 = 4'h3;
    drain("frame1_2");

    bus.bright = 3'd2;
    bus.LED2 = 4'hF;
    push_frame(4'hA, 4'h3, 4'hF, 4'h3, 2'b00, 2, 1'b1);
    drain("pwm_bright2");

    bus.bright = 3'd0;
    push_frame(4'hA, 4'h3, 4'hF, 4'h3, 2'b00, 0, 1'b1);
    drain("pwm_dark");

    bus.bright = 3'd3;
    bus.LED4 = 1'b1; bus.LED5 = 1'b0;
    push_frame(4'hA, 4'h3, 4'hF, 4'h3, 2'b01, 3, 1'b1);
    drain("aux_bright3");

    bus.bright = 3'd7;
    bus.LED5 = 1'b1; bus.LED4 = 1'b0;
    push_frame(4'hA, 4'h3, 4'hF, 4'h3, 2'b10, 7, 1'b1);
    drain("bright_full");

    // Abort during row 2, then restart with a fresh snapshot.
    bus.bright = 3'd4;
    bus.LED0 = 4'h6;
    push_frame(4'h6, 4'h3, 4'hF, 4'h3, 2'b10, 4, 1'b1);
    run(12, "pre_abort");
    bus.en = 1'b0;
    bus.LED0 = 4'h9;
    exp_q.delete();
    push_zeros(3);
    run(3, "abort");
    bus.en = 1'b1;
    push_frame(4'h9, 4'h3, 4'hF, 4'h3, 2'b10, 4, 1'b0);
    drain("restart");

    // Asynchronous reset in the middle of a drive cycle.
    push_frame(4'h9, 4'h3, 4'hF, 4'h3, 2'b10, 4, 1'b1);
    run(3, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_q.push_back(11'd0);
    check_now("async_reset");
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_zeros(2);
    run(2, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
